// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S line-in receiver with ADC clock generation and single-entry sample stream
module i2s_rx #(
    parameter int sclk_div_log2_p = 3,
    parameter int width_p         = 24
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    output logic               rx_mclk_o,
    output logic               rx_lrck_o,
    output logic               rx_sclk_o,
    input  logic               rx_sdin_i,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic               overrun_o
);

    localparam int S  = sclk_div_log2_p;
    localparam int CW = S + 6;

    // One clk after the sclk rising edge, so sdin_r already holds the bit the ADC launched.
    localparam logic [S-1:0] STROBE_PHASE = S'((2 ** (S - 1)) + 1);
    localparam logic [4:0]   LAST_BIT     = 5'(width_p);

    logic [CW-1:0]      count_r;
    logic               sdin_r;
    logic [4:0]         bit_idx;
    logic               chan;
    logic               strobe;
    logic               capture;
    logic               complete;
    logic [width_p-1:0] word;

    assign bit_idx  = count_r[S+4:S];
    assign chan     = count_r[S+5];
    assign strobe   = (count_r[S-1:0] == STROBE_PHASE);
    assign capture  = strobe && (bit_idx != 5'd0) && (bit_idx <= LAST_BIT);
    assign complete = strobe && (bit_idx == LAST_BIT);

    assign rx_mclk_o = count_r[0];
    assign rx_sclk_o = count_r[S-1];
    assign rx_lrck_o = count_r[S+5];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
            sdin_r  <= 1'b0;
        end else begin
            count_r <= count_r + CW'(1);
            sdin_r  <= rx_sdin_i;
        end
    end

    generate
        if (width_p > 1) begin : g_shift
            logic [width_p-2:0] shift_r;

            assign word = {shift_r, sdin_r};

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    shift_r <= '0;
                end else if (capture) begin
                    shift_r <= word[width_p-2:0];
                end
            end
        end else begin : g_single
            assign word = sdin_r;
        end
    endgenerate

    // Single-entry holding register; a full register with no taker drops the new word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o    <= '0;
            last_o    <= 1'b0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (complete) begin
            if (!valid_o || ready_i) begin
                data_o  <= word;
                last_o  <= chan;
                valid_o <= 1'b1;
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S line-in receiver for the Pmod I2S2 ADC. It is the receive-side counterpart of the line-out serializer.
- Generates the ADC clocks (main clock, data clock, L/R clock) from a single system clock.
- Deserializes the rx data pin into 24-bit samples and presents them as a single-entry ready/valid stream with last marking the right channel.
- Sits beside the i2s2 transmit path in top and feeds the fifo_1r1w/volume chain from line-in.

Parameters:
- sclk_div_log2_p, 3: log2 of clk_i cycles per data-clock period; legal range 2..5.
- width_p, 24: sample width in bits; legal range 1..31; bits beyond width_p in each 32-bit slot are ignored.

Ports:
- clk_i  in  1  system clock (PLL output).
- reset_n_i  in  1  asynchronous, active-low reset.
- rx_mclk_o  out  1  ADC main clock.
- rx_lrck_o  out  1  L/R select: 0 = left, 1 = right.
- rx_sclk_o  out  1  data clock.
- rx_sdin_i  in  1  serial data from ADC; changes on falling edge of rx_sclk_o.
- data_o  out  width_p  received sample, MSB-aligned as sent.
- valid_o  out  1  data_o/last_o hold a sample.
- ready_i  in  1  consumer accepts the sample when valid_o & ready_i.
- last_o  out  1  1 = right-channel sample (end of stereo frame).
- overrun_o  out  1  sticky flag: a completed sample was dropped.

Behaviour:
- Clock generation:
  - Let S = sclk_div_log2_p. There is a free-running counter count_r of width S+6, incrementing every clk_i and wrapping to 0.
  - rx_mclk_o = count_r[0], i.e. clk/2. With S=3 this gives 256·fs.
  - rx_sclk_o = count_r[S-1].
  - rx_lrck_o = count_r[S+5].
  - Frame length: 64 sclk periods, 32 sclk per channel.
- Slot decode: bit index b = count_r[S+4:S] (0..31); channel ch = count_r[S+5].
- Input stage: rx_sdin_i is registered once into sdin_r every clk_i.
- Sample strobe: fires in the cycle where count_r[S-1:0] == 2^(S-1)+1, i.e. one clk after the rising edge of sclk. This compensates for the input register.
- Bit capture (I2S one-bit delay):
  - Slot b=0 is ignored.
  - Slots b=1..width_p are shifted MSB-first into shift_r.
  - Slots b>width_p are ignored.
- Word completion happens at the strobe with b==width_p:
  - The completed word is {shift_r[width_p-2:0], sdin_r}, with last = ch.
  - If the holding register is empty, or valid_o & ready_i in the same cycle: load data_o/last_o and set valid_o=1 on the next clk_i edge.
  - If the holding register is full and ready_i=0: discard the new word, keep the held word unchanged, and set overrun_o=1 (sticky until reset).
- Handshake:
  - valid_o stays high and data_o/last_o stay stable until valid_o & ready_i.
  - On that transfer, valid_o clears next cycle unless a word completes in that same cycle, in which case the new word is loaded and valid_o stays 1.
  - valid_o never depends combinationally on ready_i.
- Latency: rising clk_i edge after the LSB strobe → valid_o=1. That is one clk after the strobe cycle.
- Reset (asynchronous, reset_n_i=0):
  - count_r=0, shift_r=0, sdin_r=0.
  - rx_mclk_o=rx_sclk_o=rx_lrck_o=0.
  - data_o=0, last_o=0, valid_o=0, overrun_o=0.
  - Reset mid-frame discards the partial word and any held word.
  - After release, the counter restarts at 0. The first sample produced is the left word of the first complete frame.
- Wrap-around: count_r rollover from all-ones to 0 is seamless. The right-channel LSB of one frame and the left-channel slot b=0 of the next frame need no special handling.

Test Plan:
- Reset check: hold reset_n_i=0 and toggle clk_i.
  - Required: all outputs 0.
  - Release reset, S=3: rx_sclk_o rises at clk 4, rx_lrck_o rises at clk 256, rx_mclk_o toggles every clk.
- Stereo capture: the bench drives left=0xA5A5A5 and right=0x123456 in I2S format, with bits 25..31 driven to 1, and ready_i=1.
  - Required: exactly two beats per frame, 0xA5A5A5/last_o=0 then 0x123456/last_o=1.
  - Required: overrun_o=0.
- Latency: measure clk cycles from the left LSB strobe (count_r=0x0C5 at S=3) to valid_o=1.
  - Required: 1 cycle.
- Backpressure/overrun: ready_i=0 for a full frame carrying left=0x000001 and right=0xFFFFFF.
  - Required: valid_o=1, data_o=0x000001, last_o=0 held throughout; right word dropped; overrun_o=1.
  - Raise ready_i: one beat transfers, valid_o falls, overrun_o stays 1.
- Simultaneous accept+complete: hold ready_i=0 after the left word, then pulse ready_i=1 exactly in the right-LSB strobe cycle.
  - Required: the left word is transferred and the right word is loaded the next cycle.
  - Required: valid_o stays 1 with no bubble, and overrun_o=0.
- Reset mid-frame: assert reset_n_i=0 at right-channel bit 12, then release.
  - Required: no partial word is emitted.
  - Required: the first beat after release is the left word of the next full frame, with last_o=0.
